logiccore9_datapath: RTL and testbench
======================================

Name: logiccore9_datapath

Overview:
- Datapath stage directly downstream of the LogicCore9 controller; consumes its per-cycle control word (In, Bus2, AU1B3, AU1B4, Bus5, Bus7, LR, OP, DONE).
- Holds five signed operand/result registers R0..R4 and a 4-bit-opcode arithmetic/bitwise unit (ALU).
- Registers Z/N/V flags and presents a held Result with a one-cycle Valid pulse when the controller signals DONE.

Parameters:
- WIDTH, 8, operand/register width in bits, two's complement signed.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- Data_in  input  WIDTH  external signed operand.
- In  input  1  Bus1 source select: 1 = Data_in, 0 = ALU result.
- Bus2  input  2  ALU operand A select: 00 R0, 01 R1, 10 R2, 11 R3.
- Bus5  input  2  ALU operand B select: 00 R1, 01 R2, 10 R3, 11 R4.
- AU1B3  input  1  force operand B = +1.
- AU1B4  input  1  force operand B = 0.
- Bus7  input  2  Result source: 00 R0, 01 R3, 10 R4, 11 current ALU output.
- LR  input  5  LR[i]=1 loads Ri from Bus1.
- OP  input  4  ALU opcode.
- DONE  input  1  end-of-sequence from controller.
- Result  output  WIDTH  registered final result.
- Valid  output  1  one-cycle pulse when Result updates.
- Z, N, V  output  1 each  registered zero / negative / signed-overflow flags.

Behaviour:
- Reset (rst=1 at a clk edge) clears R0..R4, Result, Valid, Z, N, V and the DONE edge register to 0. Reset has priority over every load in the same cycle and aborts any sequence in progress.
- Operand B priority: AU1B3 over AU1B4 over Bus5.
- The ALU is combinational on the current register values. Register reads in a cycle see pre-edge values, so read and write of the same register in one cycle is legal.
- Register load: every Ri with LR[i]=1 takes Bus1 at the edge. Multiple LR bits set load the same value. LR=0 holds all registers.
- Opcodes:
  - 0000 A
  - 0001 A+B
  - 0010 A-B
  - 0011 B-A
  - 0100 A&B
  - 0101 A|B
  - 0110 A^B
  - 0111 ~A
  - 1000 -A
  - 1001 A<<1
  - 1010 A>>>1 (arithmetic)
  - 1011 |A|
  - 1100 signed max(A,B)
  - 1101 signed min(A,B)
  - 1110 A+1
  - 1111 result 0
- Arithmetic wraps modulo 2^WIDTH.
- V=1 on signed overflow for add, subtract, negate, abs and shl: e.g. -128 negated gives -128 with V=1. Logic opcodes give V=0.
- Flags update only on edges where In=0 and LR≠0, from the value written. Otherwise they hold.
- DONE edge detect: on the first edge where DONE=1 and the registered previous DONE=0:
  - Result <= Bus7 selection (pre-edge values);
  - Valid=1 for exactly that cycle.
- DONE held high for further cycles gives no further Valid pulses and Result holds.
- DONE and LR active in the same cycle: Result captures the pre-load value; the load still occurs.
- Latency: Data_in to Ri is 1 cycle; an ALU op to Ri is 1 cycle; DONE to Result/Valid is 1 cycle.

Optional Feature:
- Macro LOGICCORE9_SAT_EN.
- Defined: opcodes 0001, 0010, 0011, 1000, 1011, 1110 saturate to +2^(WIDTH-1)-1 or -2^(WIDTH-1) on signed overflow. V still reports the overflow, e.g. 100+100 gives 127 with V=1.
- Undefined: wrap-around as specified above.

Test Plan:
- Load: Data_in=25, In=1, LR=00001; then Data_in=-7, LR=00010 -> R0=25, R1=-7. Then Bus2=00, Bus5=00, OP=0001, In=0, LR=00100 -> R2=18, Z=0, N=0, V=0.
- Overflow: R0=100, R1=100, OP=0001, LR=01000 -> R3=-56, V=1, N=1. With LOGICCORE9_SAT_EN -> R3=127, V=1.
- Operand overrides: R0=-1, AU1B3=1, AU1B4=1, OP=0001 -> result 0, Z=1 (AU1B3 wins). AU1B4 alone with OP=0010 -> result -1, N=1.
- DONE: Bus7=01, R3=42, DONE high for 3 cycles -> Result=42 one cycle later, Valid high exactly 1 cycle. Raise DONE again after a low cycle -> second pulse.
- Reset mid-sequence: registers loaded, flags set, rst=1 for 1 cycle while LR=11111 -> all registers, flags, Result and Valid are 0 the next cycle.
- Edge ops: A=-128 with OP=1000 and OP=1011 -> -128, V=1 (wrap); OP=1010 on -5 -> -3; OP=1111 -> 0, Z=1.

Source files
------------

// File: rtl/logiccore9_datapath.sv
// LogicCore9 datapath: five signed registers, a 16-opcode ALU, Z/N/V flags and a DONE-captured Result.
// Optional build macro LOGICCORE9_SAT_EN: arithmetic opcodes (except shift-left) saturate on signed overflow.
module logiccore9_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] Data_in,
    input  logic                    In,
    input  logic [1:0]              Bus2,
    input  logic [1:0]              Bus5,
    input  logic                    AU1B3,
    input  logic                    AU1B4,
    input  logic [1:0]              Bus7,
    input  logic [4:0]              LR,
    input  logic [3:0]              OP,
    input  logic                    DONE,
    output logic signed [WIDTH-1:0] Result,
    output logic                    Valid,
    output logic                    Z,
    output logic                    N,
    output logic                    V
);

    typedef enum logic [3:0] {
        OP_PASS = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_RSB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_NOT  = 4'h7,
        OP_NEG  = 4'h8,
        OP_SHL  = 4'h9,
        OP_ASR  = 4'hA,
        OP_ABS  = 4'hB,
        OP_MAX  = 4'hC,
        OP_MIN  = 4'hD,
        OP_INC  = 4'hE,
        OP_ZERO = 4'hF
    } op_e;

    localparam logic signed [WIDTH-1:0] one_w   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [WIDTH-1:0] sat_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] sat_min = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] r [5];
    logic signed [WIDTH-1:0] opa, opb, alu_y, bus1, bus7_y;
    logic signed [WIDTH:0]   a_x, b_x, ext;
    logic                    arith, ovf, done_q;
    op_e                     op;

    assign op = op_e'(OP);

    // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
    always_comb begin : operand_sel
        opa = r[Bus2];
        opb = '0;
        if (AU1B3) begin
            opb = one_w;
        end else if (AU1B4) begin
            opb = '0;
        end else begin
            case (Bus5)
                2'd0:    opb = r[1];
                2'd1:    opb = r[2];
                2'd2:    opb = r[3];
                default: opb = r[4];
            endcase
        end
    end

    // Arithmetic ops are evaluated one bit wider so overflow is simply "top two bits differ".
    always_comb begin : alu
        a_x   = {opa[WIDTH-1], opa};
        b_x   = {opb[WIDTH-1], opb};
        ext   = '0;
        arith = 1'b0;
        alu_y = '0;
        case (op)
            OP_PASS: alu_y = opa;
            OP_ADD:  begin ext = a_x + b_x;    arith = 1'b1; end
            OP_SUB:  begin ext = a_x - b_x;    arith = 1'b1; end
            OP_RSB:  begin ext = b_x - a_x;    arith = 1'b1; end
            OP_AND:  alu_y = opa & opb;
            OP_OR:   alu_y = opa | opb;
            OP_XOR:  alu_y = opa ^ opb;
            OP_NOT:  alu_y = ~opa;
            OP_NEG:  begin ext = -a_x;         arith = 1'b1; end
            OP_SHL:  begin ext = {opa, 1'b0};  arith = 1'b1; end
            OP_ASR:  alu_y = opa >>> 1;
            OP_ABS:  begin ext = opa[WIDTH-1] ? -a_x : a_x; arith = 1'b1; end
            OP_MAX:  alu_y = (opa > opb) ? opa : opb;
            OP_MIN:  alu_y = (opa < opb) ? opa : opb;
            OP_INC:  begin ext = a_x + {{WIDTH{1'b0}}, 1'b1}; arith = 1'b1; end
            default: alu_y = '0;
        endcase
        ovf = arith & (ext[WIDTH] ^ ext[WIDTH-1]);
        if (arith) alu_y = ext[WIDTH-1:0];
`ifdef LOGICCORE9_SAT_EN
        if (ovf && op != OP_SHL) alu_y = ext[WIDTH] ? sat_min : sat_max;
`endif
    end

    always_comb begin : bus_sel
        bus1 = In ? Data_in : alu_y;
        case (Bus7)
            2'd0:    bus7_y = r[0];
            2'd1:    bus7_y = r[3];
            2'd2:    bus7_y = r[4];
            default: bus7_y = alu_y;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every read in this edge sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register file is a handful of flops, not a RAM, so clearing it on reset is cheap and required.
            for (int i = 0; i < 5; i++) r[i] <= '0;
            Result <= '0;
            Valid  <= 1'b0;
            Z      <= 1'b0;
            N      <= 1'b0;
            V      <= 1'b0;
            done_q <= 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (LR[i]) r[i] <= bus1;
            end
            if (!In && LR != '0) begin
                Z <= (bus1 == '0);
                N <= bus1[WIDTH-1];
                V <= ovf;
            end
            Valid <= DONE & ~done_q;
            if (DONE && !done_q) Result <= bus7_y;
            done_q <= DONE;
        end
    end

endmodule

// File: tb/tb_logiccore9_datapath.sv
// Self-checking bench for logiccore9_datapath: integer reference model, per-cycle compare, directed and random stimulus.
module tb_logiccore9_datapath;

`ifdef LOGICCORE9_SAT_EN
    localparam bit sat = 1'b1;
`else
    localparam bit sat = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] Data_in;
    logic              In, AU1B3, AU1B4, DONE;
    logic [1:0]        Bus2, Bus5, Bus7;
    logic [4:0]        LR;
    logic [3:0]        OP;
    logic signed [7:0] Result;
    logic              Valid, Z, N, V;

    logiccore9_datapath #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .Data_in(Data_in), .In(In), .Bus2(Bus2), .Bus5(Bus5),
        .AU1B3(AU1B3), .AU1B4(AU1B4), .Bus7(Bus7), .LR(LR), .OP(OP), .DONE(DONE),
        .Result(Result), .Valid(Valid), .Z(Z), .N(N), .V(V)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: true integer result, then wrap or clamp to the 8-bit signed range.
    function automatic void alu_model(input int a, input int b, input int op, output int res, output bit v);
        int t;
        bit ar;
        t = 0; ar = 1'b0; res = 0; v = 1'b0;
        case (op)
            0:  res = a;
            1:  begin t = a + b; ar = 1'b1; end
            2:  begin t = a - b; ar = 1'b1; end
            3:  begin t = b - a; ar = 1'b1; end
            4:  res = a & b;
            5:  res = a | b;
            6:  res = a ^ b;
            7:  res = -a - 1;
            8:  begin t = -a; ar = 1'b1; end
            9:  begin t = 2 * a; ar = 1'b1; end
            10: res = a >>> 1;
            11: begin t = (a < 0) ? -a : a; ar = 1'b1; end
            12: res = (a > b) ? a : b;
            13: res = (a < b) ? a : b;
            14: begin t = a + 1; ar = 1'b1; end
            default: res = 0;
        endcase
        if (ar) begin
            v   = (t > 127) || (t < -128);
            res = ((t + 128) & 255) - 128;
            if (sat && v && op != 9) res = (t > 0) ? 127 : -128;
        end
    endfunction

    int m_r [5];
    int m_res;
    bit m_valid, m_z, m_n, m_v, m_done, model_ok = 1'b0;

    always @(posedge clk) begin
        int a, b, y, bus1, sel;
        bit ov;
        if (rst) begin
            for (int i = 0; i < 5; i++) m_r[i] = 0;
            m_res = 0; m_valid = 0; m_z = 0; m_n = 0; m_v = 0; m_done = 0;
            model_ok = 1'b1;
        end else begin
            a = m_r[Bus2];
            b = AU1B3 ? 1 : (AU1B4 ? 0 : m_r[int'(Bus5) + 1]);
            alu_model(a, b, int'(OP), y, ov);
            bus1 = In ? int'(Data_in) : y;
            case (Bus7)
                2'd0:    sel = m_r[0];
                2'd1:    sel = m_r[3];
                2'd2:    sel = m_r[4];
                default: sel = y;
            endcase
            m_valid = DONE && !m_done;
            if (m_valid) m_res = sel;
            m_done = DONE;
            for (int i = 0; i < 5; i++) if (LR[i]) m_r[i] = bus1;
            if (!In && LR != 0) begin
                m_z = (bus1 == 0);
                m_n = (bus1 < 0);
                m_v = ov;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("Result", Result, m_res);
            check("Valid", Valid, m_valid);
            check("Z", Z, m_z);
            check("N", N, m_n);
            check("V", V, m_v);
            for (int i = 0; i < 5; i++) check($sformatf("R%0d", i), dut.r[i], m_r[i]);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr();
        rst = 0; Data_in = 0; In = 0; Bus2 = 0; Bus5 = 0; AU1B3 = 0; AU1B4 = 0;
        Bus7 = 0; LR = 0; OP = 0; DONE = 0;
    endtask

    task automatic ld(input int idx, input int val);
        clr();
        In = 1; Data_in = 8'(val); LR = 5'(1 << idx);
        tick();
    endtask

    initial begin
        clr();
        rst = 1;
        tick();
        tick();
        rst = 0;
        tick();
        check("rst_result", Result, 0);
        check("rst_valid", Valid, 0);
        check("rst_z", Z, 0);

        // Load and add
        ld(0, 25);
        ld(1, -7);
        clr(); OP = 4'b0001; LR = 5'b00100; tick();
        check("add_r2", dut.r[2], 18);
        check("model_r2", m_r[2], 18);
        check("add_z", Z, 0);
        check("add_n", N, 0);
        check("add_v", V, 0);

        // Signed overflow on add
        ld(0, 100);
        ld(1, 100);
        clr(); OP = 4'b0001; LR = 5'b01000; tick();
        check("ovf_r3", dut.r[3], sat ? 127 : -56);
        check("model_ovf_r3", m_r[3], sat ? 127 : -56);
        check("ovf_v", V, 1);
        check("ovf_n", N, sat ? 0 : 1);

        // Operand B overrides
        ld(0, -1);
        clr(); AU1B3 = 1; AU1B4 = 1; OP = 4'b0001; LR = 5'b10000; tick();
        check("b3_r4", dut.r[4], 0);
        check("b3_z", Z, 1);
        clr(); AU1B4 = 1; OP = 4'b0010; LR = 5'b10000; tick();
        check("b4_r4", dut.r[4], -1);
        check("b4_n", N, 1);

        // DONE edge detection
        ld(3, 42);
        clr(); Bus7 = 2'b01; DONE = 1; tick();
        check("done1_result", Result, 42);
        check("done1_valid", Valid, 1);
        tick();
        check("done2_valid", Valid, 0);
        check("done2_result", Result, 42);
        tick();
        check("done3_valid", Valid, 0);
        DONE = 0; tick();
        DONE = 1; tick();
        check("done_again_valid", Valid, 1);
        DONE = 0; tick();
        DONE = 1; In = 1; Data_in = 5; LR = 5'b01000; tick();
        check("done_ld_result", Result, 42);
        check("done_ld_r3", dut.r[3], 5);
        clr(); tick();

        // Reset mid-sequence
        ld(0, 33);
        clr(); OP = 4'b1111; LR = 5'b00010; tick();
        check("zero_z", Z, 1);
        clr(); rst = 1; In = 1; Data_in = 9; LR = 5'b11111; DONE = 1; tick();
        check("rst_mid_r0", dut.r[0], 0);
        check("rst_mid_z", Z, 0);
        check("rst_mid_valid", Valid, 0);
        check("rst_mid_result", Result, 0);

        // Edge opcodes
        ld(0, -128);
        clr(); OP = 4'b1000; LR = 5'b00010; tick();
        check("neg_min", dut.r[1], sat ? 127 : -128);
        check("neg_min_v", V, 1);
        clr(); OP = 4'b1011; LR = 5'b00100; tick();
        check("abs_min", dut.r[2], sat ? 127 : -128);
        check("abs_min_v", V, 1);
        ld(0, -5);
        clr(); OP = 4'b1010; LR = 5'b00010; tick();
        check("asr_m5", dut.r[1], -3);
        check("asr_v", V, 0);
        clr(); OP = 4'b1111; LR = 5'b00010; tick();
        check("op_zero", dut.r[1], 0);
        check("op_zero_z", Z, 1);

        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            rst     = ($urandom_range(0, 63) == 0);
            Data_in = 8'($urandom);
            In      = ($urandom_range(0, 2) == 0);
            Bus2    = 2'($urandom);
            Bus5    = 2'($urandom);
            AU1B3   = ($urandom_range(0, 3) == 0);
            AU1B4   = ($urandom_range(0, 3) == 0);
            Bus7    = 2'($urandom);
            LR      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            OP      = 4'($urandom);
            DONE    = 1'($urandom);
            tick();
        end

        clr();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
